// File: rtl/mb_bank_arbiter_if.sv
// Bus bundle between requesters, the per-bank arbiter and the bank storage.
// The slave view belongs to the arbiter; the master view is its surroundings.
interface mb_bank_arbiter_if #(
   parameter int REQUESTERS = 3,
   parameter int DATA_WIDTH = 17,
   parameter int ADDR_WIDTH = 17
);
   logic [REQUESTERS-1:0]            rq_valid;
   logic [REQUESTERS-1:0]            rq_we;
   logic [REQUESTERS*ADDR_WIDTH-1:0] rq_addr;
   logic [REQUESTERS*DATA_WIDTH-1:0] rq_wdata;
   logic [REQUESTERS-1:0]            rq_ready;
   logic                             mem_ready;
   logic                             mem_en;
   logic                             mem_we;
   logic [ADDR_WIDTH-1:0]            mem_addr;
   logic [DATA_WIDTH-1:0]            mem_wdata;
   logic [DATA_WIDTH-1:0]            mem_rdata;
   logic [REQUESTERS-1:0]            rsp_valid;
   logic [DATA_WIDTH-1:0]            rsp_rdata;
   logic [31:0]                      txn_cnt;
   logic [REQUESTERS-1:0]            timeout;

   modport slave (
      input  rq_valid, rq_we, rq_addr, rq_wdata, mem_ready, mem_rdata,
      output rq_ready, mem_en, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_rdata, txn_cnt, timeout
   );

   modport master (
      output rq_valid, rq_we, rq_addr, rq_wdata, mem_ready, mem_rdata,
      input  rq_ready, mem_en, mem_we, mem_addr, mem_wdata,
             rsp_valid, rsp_rdata, txn_cnt, timeout
   );
endinterface

// File: rtl/mb_bank_arbiter.sv
// Round-robin arbiter in front of one single-port memory bank: grants one requester per
// cycle, rebases the address to the bank, tags reads for their 1-cycle response.
module mb_bank_arbiter #(
   parameter int REQUESTERS = 3,
   parameter int BANKS      = 2,
   parameter int BANK_ID    = 0,
   parameter int DATA_WIDTH = 17,
   parameter int ADDR_WIDTH = 17,
   parameter int TIME_OUT   = 3000
) (
   input  logic             clk,
   input  logic             rst,
   mb_bank_arbiter_if.slave bus
);
   localparam int PW = (REQUESTERS > 1) ? $clog2(REQUESTERS) : 1;
   localparam int WW = $clog2(TIME_OUT + 1);
   localparam longint BANK_SIZE = (((longint'(1) << ADDR_WIDTH) - 1) / BANKS) + 1;
   localparam logic [ADDR_WIDTH-1:0] BANK_BASE = ADDR_WIDTH'(BANK_SIZE * BANK_ID);
   localparam logic [PW:0]   REQ_N     = (PW+1)'(REQUESTERS);
   localparam logic [PW-1:0] LAST_ID   = PW'(REQUESTERS - 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(TIME_OUT);
   localparam logic [WW-1:0] WAIT_TRIP = WW'(TIME_OUT - 1);

   logic [PW-1:0]         rr_ptr;
   logic [PW-1:0]         grant_id;
   logic                  grant;
   logic                  tag_valid;
   logic [PW-1:0]         tag_id;
   logic                  sel_we;
   logic [ADDR_WIDTH-1:0] sel_addr;
   logic [DATA_WIDTH-1:0] sel_wdata;
   logic [31:0]           txn_cnt_q;
   logic [WW-1:0]         wait_cnt [REQUESTERS];
   logic [REQUESTERS-1:0] timeout_q;

   // First valid requester at or after rr_ptr, wrapping modulo REQUESTERS.
   always_comb begin : scan
      logic       found;
      logic [PW:0] idx;
      found    = 1'b0;
      grant_id = '0;
      idx      = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         idx = {1'b0, rr_ptr} + (PW+1)'(k);
         if (idx >= REQ_N) idx = idx - REQ_N;
         if (!found && bus.rq_valid[idx[PW-1:0]]) begin
            found    = 1'b1;
            grant_id = idx[PW-1:0];
         end
      end
      grant = found && bus.mem_ready && !rst;
   end

   always_comb begin
      sel_we        = 1'b0;
      sel_addr      = '0;
      sel_wdata     = '0;
      bus.rq_ready  = '0;
      bus.rsp_valid = '0;
      for (int k = 0; k < REQUESTERS; k++) begin
         if (grant_id == PW'(k)) begin
            sel_we    = bus.rq_we[k];
            sel_addr  = bus.rq_addr[k*ADDR_WIDTH +: ADDR_WIDTH];
            sel_wdata = bus.rq_wdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
         bus.rq_ready[k]  = grant && (grant_id == PW'(k));
         bus.rsp_valid[k] = tag_valid && !rst && (tag_id == PW'(k));
      end
   end

   assign bus.mem_en    = grant;
   assign bus.mem_we    = sel_we;
   assign bus.mem_addr  = sel_addr - BANK_BASE;
   assign bus.mem_wdata = sel_wdata;
   assign bus.rsp_rdata = bus.mem_rdata;
   assign bus.txn_cnt   = txn_cnt_q;
   assign bus.timeout   = timeout_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         rr_ptr    <= '0;
         tag_valid <= 1'b0;
         tag_id    <= '0;
         txn_cnt_q <= '0;
         timeout_q <= '0;
         for (int k = 0; k < REQUESTERS; k++) wait_cnt[k] <= '0;
      end else begin
         tag_valid <= grant && !sel_we;
         tag_id    <= grant_id;
         if (grant) begin
            rr_ptr <= (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
            if (txn_cnt_q != '1) txn_cnt_q <= txn_cnt_q + 32'd1;
         end
         // Starvation: count cycles spent valid but not granted; the flag is sticky.
         for (int k = 0; k < REQUESTERS; k++) begin
            if (!bus.rq_valid[k] || bus.rq_ready[k]) begin
               wait_cnt[k] <= '0;
            end else begin
               if (wait_cnt[k] == WAIT_TRIP) timeout_q[k] <= 1'b1;
               if (wait_cnt[k] != WAIT_MAX) wait_cnt[k] <= wait_cnt[k] + 1'b1;
            end
         end
      end
   end
endmodule
